// File: rtl/pixel_feeder_pkg.sv
// Shared types and defaults for the pixel feeder: pacing FSM states, debug
// view of the internal counters and a counter-width helper.
package pixel_feeder_pkg;

  localparam int PF_DATA_W = 8;
  localparam int PF_DEPTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Internal state made visible for checkers; counters are zero-extended.
  typedef struct packed {
    state_t      state;
    logic [15:0] line_cnt;
    logic [15:0] gap_cnt;
  } pf_dbg_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with a separate occupancy counter; head word is read
// combinationally so a pop and its data land on the same edge.
module pix_fifo
  import pixel_feeder_pkg::*;
#(
  parameter int DATA_W = PF_DATA_W,
  parameter int DEPTH  = PF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rd_data = mem[rd_ptr];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !rstn && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers source pixels and hands them downstream one per pix_req strobe,
// spaced by GAP idle cycles, with line_end marking each LINE_LEN-th pixel.
module pixel_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int DATA_W   = PF_DATA_W,
  parameter int DEPTH    = PF_DEPTH,
  parameter int GAP      = 0,
  parameter int LINE_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [DATA_W-1:0]      pixel_in,
  output logic                   pix_req,
  output logic                   line_end,
  output logic [$clog2(DEPTH):0] level,
  output pf_dbg_t                dbg
);

  localparam int LC_W = cnt_w(LINE_LEN);
  localparam int GW   = cnt_w(GAP);
  localparam logic [LC_W-1:0] LC_LAST  = LC_W'(LINE_LEN - 1);
  localparam logic [GW-1:0]   GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  // Source handshake: a word transfers on any cycle where src_valid and
  // src_ready are both high; src_ready depends only on registered state
  // plus flush/rstn, never on src_valid.
  state_t            state;
  logic [GW-1:0]     gap_cnt;
  logic [LC_W-1:0]   line_cnt;
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              emit;

  assign src_ready = !fifo_full && !flush && !rstn;
  assign wr_en     = src_valid && src_ready;
  assign emit      = (state == IDLE) && en && !fifo_empty && !flush && !rstn;

  pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (flush),
    .wr_en   (wr_en),
    .wr_data (src_data),
    .rd_en   (emit),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      line_cnt <= '0;
      pixel_in <= '0;
      pix_req  <= 1'b0;
      line_end <= 1'b0;
    end else if (flush) begin
      // pixel_in keeps its last value across a flush.
      state    <= IDLE;
      gap_cnt  <= '0;
      line_cnt <= '0;
      pix_req  <= 1'b0;
      line_end <= 1'b0;
    end else begin
      pix_req  <= 1'b0;
      line_end <= 1'b0;
      case (state)
        IDLE: begin
          if (emit) begin
            pixel_in <= head;
            pix_req  <= 1'b1;
            line_end <= (line_cnt == LC_LAST);
            line_cnt <= (line_cnt == LC_LAST) ? '0 : line_cnt + 1'b1;
            if (GAP > 0) begin
              state   <= HOLD;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        HOLD: begin
          // Gap runs down whether or not en is high.
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg.state    = state;
  assign dbg.line_cnt = 16'(line_cnt);
  assign dbg.gap_cnt  = 16'(gap_cnt);

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed and random stimulus for pixel_feeder, checked every cycle against
// a queue-based model that tracks emit times by absolute cycle number.
module tb_pixel_feeder;
  import pixel_feeder_pkg::*;

  localparam int DW       = 8;
  localparam int DEPTH    = 8;
  localparam int GAP      = 2;
  localparam int LINE_LEN = 4;
  localparam int LW       = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] pixel_in;
  logic          pix_req;
  logic          line_end;
  logic [LW-1:0] level;
  pf_dbg_t       dbg;

  always #5 clk = ~clk;

  pixel_feeder #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .GAP      (GAP),
    .LINE_LEN (LINE_LEN)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .flush     (flush),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .pixel_in  (pixel_in),
    .pix_req   (pix_req),
    .line_end  (line_end),
    .level     (level),
    .dbg       (dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_pix;
  logic          m_req;
  logic          m_end;
  int            m_line;
  int            m_cyc;
  int            m_next;
  int            n_chk;
  int            n_err;
  int            n_strobes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the negedge, check src_ready, advance the
  // model, then check registered outputs just after the rising edge.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic e,
                      input logic f, input logic r, output logic acc);
    logic exp_rdy;
    logic do_emit;
    src_valid = v;
    src_data  = d;
    en        = e;
    flush     = f;
    rstn      = r;
    #1;
    exp_rdy = !r && !f && (exp_q.size() < DEPTH);
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (r) begin
      exp_q.delete();
      m_pix  = '0;
      m_req  = 1'b0;
      m_end  = 1'b0;
      m_line = 0;
      m_next = 0;
    end else if (f) begin
      exp_q.delete();
      m_req  = 1'b0;
      m_end  = 1'b0;
      m_line = 0;
      m_next = 0;
    end else begin
      do_emit = e && (exp_q.size() > 0) && (m_cyc >= m_next);
      m_req = do_emit;
      m_end = 1'b0;
      if (do_emit) begin
        m_pix  = exp_q.pop_front();
        m_end  = (m_line == LINE_LEN - 1);
        m_line = (m_line + 1) % LINE_LEN;
        m_next = m_cyc + GAP + 1;
        n_strobes++;
      end
      if (acc) exp_q.push_back(d);
    end
    m_cyc++;
    @(posedge clk);
    #1;
    chk("pix_req", 32'(pix_req), 32'(m_req));
    chk("pixel_in", 32'(pixel_in), 32'(m_pix));
    chk("line_end", 32'(line_end), 32'(m_end));
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("line_cnt", 32'(dbg.line_cnt), 32'(m_line));
    @(negedge clk);
  endtask

  task automatic idle(input logic e, input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, e, 1'b0, 1'b0, acc);
  endtask

  // Source holds the word until it is taken; a bounded wait.
  task automatic push_px(input logic [DW-1:0] d, input logic e);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      tick(1'b1, d, e, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) chk("push_timeout", 32'(tries), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          acc;
    logic [DW-1:0] d;
    int            s0;
    n_chk = 0; n_err = 0; n_strobes = 0;
    m_pix = '0; m_req = 1'b0; m_end = 1'b0; m_line = 0; m_cyc = 0; m_next = 0;
    @(negedge clk);

    // Reset, then a single write of 0xA5 at cycle 10.
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, acc);
    chk("reset_state", 32'(dbg.state), 32'(IDLE));
    idle(1'b1, 10 - m_cyc);
    s0 = n_strobes;
    tick(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, acc);
    idle(1'b1, 6);
    chk("a5_strobe_count", 32'(n_strobes - s0), 32'(1));

    // Preload 0x01..0x04 with en low, then release: one strobe per GAP+1.
    for (int i = 1; i <= 4; i++) push_px(DW'(i), 1'b0);
    chk("preload_level", 32'(level), 32'(4));
    idle(1'b1, 14);

    // Fill past DEPTH with en low; the ninth word waits for the first read.
    for (int i = 0; i < 9; i++) push_px(DW'($urandom_range(0, 255)), (i == 8));
    idle(1'b1, 30);

    // Line framing: ten pixels after a flush leave line_cnt at 2.
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 10; i++) push_px(DW'($urandom_range(0, 255)), 1'b1);
    idle(1'b1, 30);
    chk("line_cnt_after_10", 32'(dbg.line_cnt), 32'(2));

    // Flush with level 5 and a write offered in the same cycle.
    for (int i = 0; i < 5; i++) push_px(DW'($urandom_range(0, 255)), 1'b0);
    chk("pre_flush_level", 32'(level), 32'(5));
    tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, acc);
    chk("flush_level", 32'(level), 32'(0));
    push_px(8'h5C, 1'b1);
    idle(1'b1, 5);

    // Reset while holding off the next strobe with three words queued.
    idle(1'b0, 4);
    for (int i = 0; i < 4; i++) push_px(DW'($urandom_range(0, 255)), 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("hold_state", 32'(dbg.state), 32'(HOLD));
    chk("hold_level", 32'(level), 32'(3));
    tick(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, acc);
    tick(1'b1, 8'h78, 1'b1, 1'b0, 1'b1, acc);
    chk("post_reset_state", 32'(dbg.state), 32'(IDLE));
    s0 = n_strobes;
    idle(1'b1, 8);
    chk("no_stale_strobe", 32'(n_strobes - s0), 32'(0));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      d = DW'($urandom_range(0, 255));
      tick(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) == 0), acc);
    end
    idle(1'b1, 40);
    chk("final_level", 32'(level), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
